calc_sequencer: RTL and testbench

- Sequential front end for the 8-bit four-function calculator ALU (ops 00 add, 01 subtract, 10 AND, 11 OR).
- Accepts a serial token stream (operand, operator, equals, clear) over a valid/ready handshake.
- Drives the ALU operand and operation inputs from registers and captures the ALU result.
- Presents each result downstream over a valid/ready handshake; an accepted result becomes operand A for chained calculations.

---
 rtl/calc_sequencer.sv | 115 +++++++++++
 tb/tb_calc_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Token-driven front end for the 8-bit four-function calculator ALU.
// Holds operands and operation in registers, captures ALU results and hands them downstream.
module calc_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [2:0]       fsm_state
);

  // Handshakes: a token moves on a rising edge with in_valid & in_ready; a result
  // moves on a rising edge with res_valid & res_ready. Neither side may retract early.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_A      = 3'd1,
    S_OP     = 3'd2,
    S_B      = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam logic [1:0] K_OPERAND  = 2'b00;
  localparam logic [1:0] K_OPERATOR = 2'b01;
  localparam logic [1:0] K_EQUALS   = 2'b10;
  localparam logic [1:0] K_CLEAR    = 2'b11;

  state_t state, state_next;
  logic   accept;
  logic   tok_err;
  logic   load_a, load_b, load_op, capture, clear, chain;

  assign accept = in_valid && (state != S_RESULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tok_err    = 1'b0;
    if (state == S_RESULT) begin
      if (res_ready) state_next = S_A;
    end else if (accept) begin
      case (in_kind)
        K_CLEAR:   state_next = S_IDLE;
        K_OPERAND: begin
          if (state == S_IDLE)    state_next = S_A;
          else if (state == S_OP) state_next = S_B;
        end
        K_OPERATOR: begin
          if (state == S_A)                         state_next = S_OP;
          else if (state == S_IDLE || state == S_B) tok_err    = 1'b1;
        end
        default: begin
          if (state == S_B) state_next = S_RESULT;
          else              tok_err    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != S_RESULT);
    fsm_state = state;
    load_a    = accept && (in_kind == K_OPERAND) && (state == S_IDLE || state == S_A);
    load_b    = accept && (in_kind == K_OPERAND) && (state == S_OP || state == S_B);
    load_op   = accept && (in_kind == K_OPERATOR) && (state == S_A || state == S_OP);
    capture   = accept && (in_kind == K_EQUALS) && (state == S_B);
    clear     = accept && (in_kind == K_CLEAR);
    chain     = (state == S_RESULT) && res_ready;
  end

  // res_data survives clear so the last answer stays readable downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 2'b00;
      res_data  <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= tok_err;
      if (clear) begin
        alu_a  <= '0;
        alu_b  <= '0;
        alu_op <= 2'b00;
      end else begin
        if (load_a)     alu_a <= in_data;
        else if (chain) alu_a <= res_data;
        if (load_b)  alu_b  <= in_data;
        if (load_op) alu_op <= in_data[1:0];
      end
      if (capture) begin
        res_data  <= alu_y;
        res_valid <= 1'b1;
      end else if (chain) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural ALU, token driver, result scoreboard and final report.
module tb_calc_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_kind;
  logic [W-1:0] in_data;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [1:0]   alu_op;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         err;
  logic [2:0]   fsm_state;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OPERAND  = 2'b00;
  localparam logic [1:0] OPERATOR = 2'b01;
  localparam logic [1:0] EQUALS   = 2'b10;
  localparam logic [1:0] CLEAR    = 2'b11;

  calc_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_data(in_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] calc(input logic [W-1:0] a, input logic [1:0] op,
                                        input logic [W-1:0] b);
    case (op)
      2'b00:   calc = a + b;
      2'b01:   calc = a - b;
      2'b10:   calc = a & b;
      default: calc = a | b;
    endcase
  endfunction

  assign alu_y = calc(alu_a, alu_op, alu_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: hold a token until in_ready, then check the err pulse it leaves behind
  task automatic send_token(input logic [1:0] kind, input logic [W-1:0] data, input logic exp_err);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_kind  = kind;
    in_data  = data;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check_eq("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("err", {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic compute(input logic [W-1:0] a, input logic [1:0] op, input logic [W-1:0] b);
    send_token(OPERAND, a, 1'b0);
    send_token(OPERATOR, {6'd0, op}, 1'b0);
    send_token(OPERAND, b, 1'b0);
    exp_q.push_back(calc(a, op, b));
    send_token(EQUALS, 8'h00, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_result", 1, 0);
      else                   check_eq("res_data", {24'd0, res_data}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb, rb2, prev;
    logic [1:0]   rop, rop2;
    rst_n = 1'b0; in_valid = 1'b0; in_kind = 2'b00; in_data = '0; res_ready = 1'b1;
    #3;
    check_eq("rst_alu_a", {24'd0, alu_a}, 0);
    check_eq("rst_alu_b", {24'd0, alu_b}, 0);
    check_eq("rst_alu_op", {30'd0, alu_op}, 0);
    check_eq("rst_res_valid", {31'd0, res_valid}, 0);
    check_eq("rst_res_data", {24'd0, res_data}, 0);
    check_eq("rst_err", {31'd0, err}, 0);
    check_eq("rst_state", {29'd0, fsm_state}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", {31'd0, in_ready}, 1);

    // 5 + 3, result for one cycle then chained into alu_a
    send_token(OPERAND, 8'h05, 1'b0);
    send_token(OPERATOR, 8'h00, 1'b0);
    send_token(OPERAND, 8'h03, 1'b0);
    exp_q.push_back(8'h08);
    send_token(EQUALS, 8'h00, 1'b0);
    check_eq("t1_res_valid", {31'd0, res_valid}, 1);
    check_eq("t1_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    check_eq("t1_res_valid_drop", {31'd0, res_valid}, 0);
    check_eq("t1_chain_a", {24'd0, alu_a}, 8'h08);
    check_eq("t1_state_a", {29'd0, fsm_state}, 1);

    // 5 - 7 wraps, then chained AND
    send_token(OPERAND, 8'h05, 1'b0);
    send_token(OPERATOR, 8'h01, 1'b0);
    send_token(OPERAND, 8'h07, 1'b0);
    exp_q.push_back(8'hFE);
    send_token(EQUALS, 8'h00, 1'b0);
    @(posedge clk); #1;
    send_token(OPERATOR, 8'h02, 1'b0);
    send_token(OPERAND, 8'h0C, 1'b0);
    exp_q.push_back(8'h0C);
    send_token(EQUALS, 8'h00, 1'b0);
    @(posedge clk); #1;

    // backpressure: result held, pending operand not consumed
    send_token(OPERATOR, 8'h00, 1'b0);
    send_token(OPERAND, 8'h01, 1'b0);
    res_ready = 1'b0;
    exp_q.push_back(8'h0D);
    send_token(EQUALS, 8'h00, 1'b0);
    in_valid = 1'b1; in_kind = OPERAND; in_data = 8'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'd0, in_ready}, 0);
      check_eq("bp_res_valid", {31'd0, res_valid}, 1);
      check_eq("bp_res_data", {24'd0, res_data}, 8'h0D);
      check_eq("bp_alu_a", {24'd0, alu_a}, 8'h0C);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    send_token(OPERAND, 8'h44, 1'b0);
    check_eq("bp_late_operand", {24'd0, alu_a}, 8'h44);
    check_eq("bp_state_a", {29'd0, fsm_state}, 1);

    // out-of-sequence tokens from IDLE
    send_token(CLEAR, 8'h00, 1'b0);
    check_eq("clr_state", {29'd0, fsm_state}, 0);
    send_token(OPERATOR, 8'h01, 1'b1);
    send_token(EQUALS, 8'h00, 1'b1);
    check_eq("errseq_alu_a", {24'd0, alu_a}, 0);
    check_eq("errseq_alu_op", {30'd0, alu_op}, 0);
    check_eq("errseq_state", {29'd0, fsm_state}, 0);
    @(posedge clk); #1;
    check_eq("err_clears", {31'd0, err}, 0);
    send_token(OPERAND, 8'h22, 1'b0);
    send_token(OPERAND, 8'h33, 1'b0);
    check_eq("overwrite_a", {24'd0, alu_a}, 8'h33);

    // clear mid-sequence
    send_token(CLEAR, 8'h00, 1'b0);
    send_token(OPERAND, 8'hF0, 1'b0);
    send_token(OPERATOR, 8'h03, 1'b0);
    send_token(OPERAND, 8'h0F, 1'b0);
    check_eq("pre_clr_b", {24'd0, alu_b}, 8'h0F);
    send_token(CLEAR, 8'h00, 1'b0);
    check_eq("clr_alu_a", {24'd0, alu_a}, 0);
    check_eq("clr_alu_b", {24'd0, alu_b}, 0);
    check_eq("clr_alu_op", {30'd0, alu_op}, 0);
    check_eq("clr_state_idle", {29'd0, fsm_state}, 0);
    check_eq("clr_keeps_res", {24'd0, res_data}, 8'h0D);
    send_token(EQUALS, 8'h00, 1'b1);

    // random computations with a chained second step
    for (int n = 0; n < 6; n++) begin
      ra = W'($urandom_range(0, 255)); rb = W'($urandom_range(0, 255));
      rop = 2'($urandom_range(0, 3));
      rb2 = W'($urandom_range(0, 255)); rop2 = 2'($urandom_range(0, 3));
      send_token(CLEAR, 8'h00, 1'b0);
      compute(ra, rop, rb);
      prev = calc(ra, rop, rb);
      check_eq("rnd_chain_a", {24'd0, alu_a}, {24'd0, prev});
      send_token(OPERATOR, {6'd0, rop2}, 1'b0);
      send_token(OPERAND, rb2, 1'b0);
      exp_q.push_back(calc(prev, rop2, rb2));
      send_token(EQUALS, 8'h00, 1'b0);
      @(posedge clk); #1;
    end

    // reset while a result is pending
    send_token(CLEAR, 8'h00, 1'b0);
    send_token(OPERAND, 8'h09, 1'b0);
    send_token(OPERATOR, 8'h00, 1'b0);
    send_token(OPERAND, 8'h01, 1'b0);
    res_ready = 1'b0;
    send_token(EQUALS, 8'h00, 1'b0);
    check_eq("prerst_res_valid", {31'd0, res_valid}, 1);
    check_eq("prerst_res_data", {24'd0, res_data}, 8'h0A);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_res_valid", {31'd0, res_valid}, 0);
    check_eq("async_res_data", {24'd0, res_data}, 0);
    check_eq("async_alu_a", {24'd0, alu_a}, 0);
    check_eq("async_state", {29'd0, fsm_state}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("ready_after_abort", {31'd0, in_ready}, 1);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
